lisnoc_router_input_route: RTL and testbench
============================================

Name: lisnoc_router_input_route

Overview:
- Per-virtual-channel input port stage of the LISNoC router.
- Buffers flits arriving from the upstream link and looks up the output port for each worm from a destination-indexed route table.
- Presents the head flit and a one-hot port request to the switch, where the per-output-port arbiters grant it.
- Holds the route until the worm's tail flit has been read (wormhole locking).
- One instance per vchannel per input port.

Parameters:
- flit_data_width, 32, data bits per flit
- flit_type_width, 2, type bits per flit (flit = {type, data}, type in MSBs)
- ph_dest_width, 5, destination field width; field is data[flit_data_width-1 -: ph_dest_width]
- destinations, 32, number of route table entries (at most 2^ph_dest_width)
- ports, 5, router output ports
- routes, {destinations*ports{1'b0}}, route table; entry d = routes[(d+1)*ports-1 : d*ports], one-hot
- fifo_length, 4, input buffer depth in flits (at least 2)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- link_flit  input  flit_data_width+flit_type_width  incoming flit
- link_valid  input  1  incoming flit valid
- link_ready  output  1  buffer can accept a flit
- switch_request  output  ports  one-hot port request for the head flit
- switch_flit  output  flit_data_width+flit_type_width  head flit
- switch_read  input  ports  grant/read from the output arbiters
- route_err  output  1  sticky unroutable-worm flag (only present with LISNOC_ROUTER_INPUT_ERR_EN)

Behaviour:
- Reset (asynchronous, rst=1): FIFO empty, state IDLE, route register 0.
  - Outputs during reset: link_ready=1, switch_request=0, switch_flit=0, route_err=0.
  - Reset mid-worm discards all buffered flits.
- Flit types (shared header): PAYLOAD=00, HEADER=01, LAST=10, SINGLE=11.
- Input handshake:
  - A flit is written when link_valid && link_ready.
  - link_ready = (count < fifo_length), registered-count based, no combinational path from switch_read.
  - A written flit reaches the FIFO head the next cycle at the earliest.
- State machine:
  - IDLE:
    - Head valid and type HEADER or SINGLE: latch route <= routes entry[dest], go to ACTIVE the next cycle. Lookup latency is 1 cycle; switch_request=0 while in IDLE.
    - Head valid and type PAYLOAD or LAST: protocol error; drop the flit (pop), stay in IDLE.
  - ACTIVE:
    - switch_request = route when head valid, else 0.
    - switch_flit = head flit.
    - Pop when |(switch_read & switch_request).
    - Popping a LAST or SINGLE flit returns to IDLE; otherwise stay in ACTIVE.
    - switch_read bits outside the route are ignored.
- Route table entry equal to 0 (unroutable):
  - The worm is drained: flits are popped one per cycle without requesting, up to and including LAST/SINGLE, then IDLE (state DROP).
- Throughput and stall:
  - Sustained 1 flit/cycle within a worm; header costs 1 bubble.
  - A full FIFO with switch_read=0 holds all state; no flit is lost or duplicated.
- Simultaneous events:
  - Write and pop in the same cycle: count unchanged.
  - Write into an empty FIFO while in ACTIVE: flit visible at head the next cycle.
- Destination values >= destinations are treated as unroutable.

Optional Feature:
- Macro LISNOC_ROUTER_INPUT_ERR_EN.
- When defined:
  - route_err port exists.
  - route_err is set the cycle after entering DROP, or on a stray PAYLOAD/LAST in IDLE.
  - route_err is cleared only by rst.
- When undefined:
  - route_err port is absent.
  - Drops are silent; drop behaviour is otherwise identical.

Decomposition:
- Flit type encodings and ph_dest field position go in the shared lisnoc_def.vh include, undefined in lisnoc_undef.vh.
- The buffer reuses the existing lisnoc_fifo sub-module (LENGTH=fifo_length).
- The route lookup and state machine (IDLE/ACTIVE/DROP) live in this block.

Test Plan:
- Reset, then a SINGLE flit with dest=3 and routes[3]=5'b00100, switch_read=00100 when requested.
  - Expected: switch_request=00100 two cycles after the write; popped the same cycle as switch_read; IDLE after.
- 4-flit worm (HEADER, PAYLOAD, PAYLOAD, LAST) with dest=1 and routes[1]=00010, read every cycle.
  - Expected: request asserted for 4 consecutive cycles, then 0.
  - The next worm's header to dest=0 (routes[0]=00001) switches the request only after LAST is popped.
- fifo_length=4, 6 flits offered back-to-back, switch_read=0.
  - Expected: link_ready drops after 4 writes; releasing switch_read delivers all 6 flits in order, none lost.
- Header with dest=7 where routes[7]=0, followed by PAYLOAD and LAST.
  - Expected: no switch_request; 3 flits drained; route_err=1 with the macro; next valid worm routes normally.
- Stray PAYLOAD in IDLE.
  - Expected: popped without request; route_err set with the macro.
- rst asserted mid-worm (2 flits buffered).
  - Expected: immediately link_ready=1 and switch_request=0; the FIFO is empty after reset releases.

Source files
------------

// File: rtl/lisnoc_router_input_route_pkg.sv
// Shared flit-type encodings and input-route FSM states for the LISNoC router input stage.
package lisnoc_router_input_route_pkg;

    typedef enum logic [1:0] {
        FLIT_PAYLOAD = 2'b00,
        FLIT_HEADER  = 2'b01,
        FLIT_LAST    = 2'b10,
        FLIT_SINGLE  = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } route_state_e;

    localparam int FLIT_TYPE_BITS = 2;

    function automatic logic flit_is_start(input logic [FLIT_TYPE_BITS-1:0] t);
        return (t == FLIT_HEADER) || (t == FLIT_SINGLE);
    endfunction

    function automatic logic flit_is_end(input logic [FLIT_TYPE_BITS-1:0] t);
        return (t == FLIT_LAST) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/lisnoc_fifo.sv
// Small flit FIFO: count-based in_ready, head visible combinationally (zero when empty).
module lisnoc_fifo #(
    parameter int WIDTH  = 34,
    parameter int LENGTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_flit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_flit,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int PW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CW = $clog2(LENGTH + 1);

    logic [WIDTH-1:0] mem_q [LENGTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(LENGTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count_q < CW'(LENGTH));
    assign out_valid = (count_q != '0);
    assign out_flit  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_flit;
    end

endmodule

// File: rtl/lisnoc_router_input_route.sv
// Per-vchannel router input stage: buffer, destination route lookup, wormhole lock.
// Optional sticky route_err output enabled by LISNOC_ROUTER_INPUT_ERR_EN.
module lisnoc_router_input_route
    import lisnoc_router_input_route_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ph_dest_width   = 5,
    parameter int destinations    = 32,
    parameter int ports           = 5,
    parameter logic [destinations*ports-1:0] routes = '0,
    parameter int fifo_length     = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [flit_data_width+flit_type_width-1:0] link_flit,
    input  logic                                     link_valid,
    output logic                                     link_ready,
    output logic [ports-1:0]                         switch_request,
    output logic [flit_data_width+flit_type_width-1:0] switch_flit,
    input  logic [ports-1:0]                         switch_read
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
    ,
    output logic                                     route_err
`endif
);
    localparam int FW = flit_data_width + flit_type_width;

    route_state_e        state_q, state_d;
    logic [ports-1:0]    route_q, route_d;
    logic [ports-1:0]    lookup_route;
    logic [FW-1:0]       head_flit;
    logic                head_valid;
    logic                head_pop;
    logic [FLIT_TYPE_BITS-1:0] head_type;
    logic [ph_dest_width-1:0]  head_dest;

    lisnoc_fifo #(
        .WIDTH  (FW),
        .LENGTH (fifo_length)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (link_flit),
        .in_valid  (link_valid),
        .in_ready  (link_ready),
        .out_flit  (head_flit),
        .out_valid (head_valid),
        .out_ready (head_pop)
    );

    assign head_type   = head_flit[FW-1 -: FLIT_TYPE_BITS];
    assign head_dest   = head_flit[flit_data_width-1 -: ph_dest_width];
    assign switch_flit = head_flit;

    // Out-of-range destinations fall through to an all-zero (unroutable) entry.
    always_comb begin
        lookup_route = '0;
        if (int'(head_dest) < destinations)
            lookup_route = routes[int'(head_dest)*ports +: ports];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        route_d        = route_q;
        head_pop       = 1'b0;
        switch_request = '0;
        case (state_q)
            ST_IDLE: begin
                if (head_valid) begin
                    if (flit_is_start(head_type)) begin
                        route_d = lookup_route;
                        state_d = (lookup_route == '0) ? ST_DROP : ST_ACTIVE;
                    end else begin
                        head_pop = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (head_valid) begin
                    switch_request = route_q;
                    if (|(switch_read & route_q)) begin
                        head_pop = 1'b1;
                        if (flit_is_end(head_type)) state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (head_valid) begin
                    head_pop = 1'b1;
                    if (flit_is_end(head_type)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef LISNOC_ROUTER_INPUT_ERR_EN
    logic err_q;
    logic err_set;

    assign err_set   = (state_q == ST_DROP) ||
                       ((state_q == ST_IDLE) && head_valid && !flit_is_start(head_type));
    assign route_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_lisnoc_router_input_route.sv
// Directed bench for lisnoc_router_input_route; route_err checks need LISNOC_ROUTER_INPUT_ERR_EN.
module tb_lisnoc_router_input_route;

    localparam int FW = 34;
    localparam int P  = 5;
    // routes[0]=00001, routes[1]=00010, routes[3]=00100, everything else unroutable.
    localparam logic [159:0] ROUTES = (160'd1 << 0) | (160'd1 << 6) | (160'd1 << 17);

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] link_flit;
    logic          link_valid;
    logic          link_ready;
    logic [P-1:0]  switch_request;
    logic [FW-1:0] switch_flit;
    logic [P-1:0]  switch_read;
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
    logic          route_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [FW-1:0] wr_flit  [8];
    logic [P-1:0]  exp_req  [8];
    logic [FW-1:0] exp_flit [8];
    logic [FW-1:0] bp_flit  [6];
    logic [FW-1:0] got_flit [6];

    always #5 clk = ~clk;

    lisnoc_router_input_route #(
        .flit_data_width (32),
        .flit_type_width (2),
        .ph_dest_width   (5),
        .destinations    (32),
        .ports           (P),
        .routes          (ROUTES),
        .fifo_length     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .link_flit      (link_flit),
        .link_valid     (link_valid),
        .link_ready     (link_ready),
        .switch_request (switch_request),
        .switch_flit    (switch_flit),
        .switch_read    (switch_read)
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        ,
        .route_err      (route_err)
`endif
    );

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [4:0] d, input logic [26:0] p);
        return {t, d, p};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Writes wr_flit[0..n_wr-1] back to back; after each edge k checks exp_req[k] (and exp_flit[k] when requesting).
    task automatic run_table(input string name, input int n_wr, input int n_cyc);
        for (int k = 0; k < n_cyc; k++) begin
            if (k < n_wr) begin
                link_flit  = wr_flit[k];
                link_valid = 1'b1;
            end else begin
                link_valid = 1'b0;
            end
            tick();
            check($sformatf("%s_req%0d", name, k), 64'(switch_request), 64'(exp_req[k]));
            if (exp_req[k] != '0)
                check($sformatf("%s_flit%0d", name, k), 64'(switch_flit), 64'(exp_flit[k]));
        end
        link_valid = 1'b0;
    endtask

    initial begin
        int wr_idx;
        int n_pop;
        logic will_write;

        rst         = 1'b1;
        link_flit   = '0;
        link_valid  = 1'b0;
        switch_read = '0;
        tick();
        check("rst_ready", 64'(link_ready), 64'd1);
        check("rst_req", 64'(switch_request), 64'd0);
        check("rst_flit", 64'(switch_flit), 64'd0);
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        check("rst_err", 64'(route_err), 64'd0);
`endif
        rst = 1'b0;
        tick();

        // SINGLE to dest 3: request two cycles after the write, pop on read.
        link_flit  = mk(2'b11, 5'd3, 27'h0000AB);
        link_valid = 1'b1;
        tick();
        link_valid = 1'b0;
        check("single_idle", 64'(switch_request), 64'd0);
        tick();
        check("single_req", 64'(switch_request), 64'b00100);
        check("single_flit", 64'(switch_flit), 64'(mk(2'b11, 5'd3, 27'h0000AB)));
        switch_read = 5'b00100;
        tick();
        switch_read = '0;
        check("single_pop", 64'(switch_request), 64'd0);
        tick();
        check("single_idle2", 64'(switch_request), 64'd0);

        // 4-flit worm to dest 1, then SINGLE to dest 0; read bits outside the route are present too.
        switch_read = 5'b00011;
        wr_flit[0] = mk(2'b01, 5'd1, 27'h100);
        wr_flit[1] = mk(2'b00, 5'd9, 27'h101);
        wr_flit[2] = mk(2'b00, 5'd9, 27'h102);
        wr_flit[3] = mk(2'b10, 5'd9, 27'h103);
        wr_flit[4] = mk(2'b11, 5'd0, 27'h200);
        exp_req[0] = 5'b00000; exp_flit[0] = '0;
        exp_req[1] = 5'b00010; exp_flit[1] = wr_flit[0];
        exp_req[2] = 5'b00010; exp_flit[2] = wr_flit[1];
        exp_req[3] = 5'b00010; exp_flit[3] = wr_flit[2];
        exp_req[4] = 5'b00010; exp_flit[4] = wr_flit[3];
        exp_req[5] = 5'b00000; exp_flit[5] = '0;
        exp_req[6] = 5'b00001; exp_flit[6] = wr_flit[4];
        exp_req[7] = 5'b00000; exp_flit[7] = '0;
        run_table("worm", 5, 8);
        switch_read = '0;

        // Back-pressure: 6 flits offered with no reads; only 4 fit.
        bp_flit[0] = mk(2'b01, 5'd3, 27'h300);
        for (int i = 1; i < 5; i++) bp_flit[i] = mk(2'b00, 5'd0, 27'(32'h300 + i));
        bp_flit[5] = mk(2'b10, 5'd0, 27'h305);
        wr_idx = 0;
        for (int i = 0; i < 6; i++) begin
            link_flit  = bp_flit[wr_idx];
            link_valid = 1'b1;
            check($sformatf("bp_ready%0d", i), 64'(link_ready), (i < 4) ? 64'd1 : 64'd0);
            if (link_ready) wr_idx++;
            tick();
        end
        link_valid = 1'b0;
        check("bp_written", 64'(wr_idx), 64'd4);
        tick();
        tick();
        check("bp_hold_ready", 64'(link_ready), 64'd0);
        check("bp_hold_req", 64'(switch_request), 64'b00100);
        check("bp_hold_flit", 64'(switch_flit), 64'(bp_flit[0]));
        switch_read = 5'b00100;
        n_pop = 0;
        for (int cyc = 0; cyc < 40 && n_pop < 6; cyc++) begin
            link_valid = (wr_idx < 6);
            if (wr_idx < 6) link_flit = bp_flit[wr_idx];
            will_write = link_valid && link_ready;
            if ((switch_request & switch_read) != '0) begin
                got_flit[n_pop] = switch_flit;
                n_pop++;
            end
            tick();
            if (will_write) wr_idx++;
        end
        link_valid  = 1'b0;
        switch_read = '0;
        check("bp_npop", 64'(n_pop), 64'd6);
        for (int i = 0; i < n_pop; i++)
            check($sformatf("bp_order%0d", i), 64'(got_flit[i]), 64'(bp_flit[i]));
        tick();
        check("bp_done_req", 64'(switch_request), 64'd0);
        check("bp_done_ready", 64'(link_ready), 64'd1);

        // Unroutable worm to dest 7 is drained, then SINGLE to dest 3 routes normally.
        switch_read = 5'b00100;
        wr_flit[0] = mk(2'b01, 5'd7, 27'h700);
        wr_flit[1] = mk(2'b00, 5'd3, 27'h701);
        wr_flit[2] = mk(2'b10, 5'd3, 27'h702);
        wr_flit[3] = mk(2'b11, 5'd3, 27'h703);
        for (int k = 0; k < 8; k++) begin
            exp_req[k]  = '0;
            exp_flit[k] = '0;
        end
        exp_req[5] = 5'b00100; exp_flit[5] = wr_flit[3];
        run_table("drop", 4, 7);
        switch_read = '0;
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        check("drop_err", 64'(route_err), 64'd1);
`endif

        // Stray PAYLOAD in IDLE is discarded; following SINGLE still routes.
        do_reset();
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        check("stray_err0", 64'(route_err), 64'd0);
`endif
        switch_read = 5'b00100;
        wr_flit[0] = mk(2'b00, 5'd3, 27'h800);
        wr_flit[1] = mk(2'b11, 5'd3, 27'h801);
        for (int k = 0; k < 8; k++) begin
            exp_req[k]  = '0;
            exp_flit[k] = '0;
        end
        exp_req[2] = 5'b00100; exp_flit[2] = wr_flit[1];
        run_table("stray", 2, 4);
        switch_read = '0;
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        check("stray_err", 64'(route_err), 64'd1);
`endif

        // Reset mid-worm discards the buffered flits.
        link_flit  = mk(2'b01, 5'd1, 27'h900);
        link_valid = 1'b1;
        tick();
        link_flit  = mk(2'b00, 5'd1, 27'h901);
        tick();
        link_valid = 1'b0;
        check("mid_req", 64'(switch_request), 64'b00010);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(link_ready), 64'd1);
        check("mid_rst_req", 64'(switch_request), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_post_flit", 64'(switch_flit), 64'd0);
        check("mid_post_req", 64'(switch_request), 64'd0);
        switch_read = 5'b00001;
        wr_flit[0] = mk(2'b11, 5'd0, 27'hA00);
        for (int k = 0; k < 8; k++) begin
            exp_req[k]  = '0;
            exp_flit[k] = '0;
        end
        exp_req[1] = 5'b00001; exp_flit[1] = wr_flit[0];
        run_table("post", 1, 3);
        switch_read = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
